// File: rtl/conv_stream_sequencer.sv
// Frame sequencer between an AXI-Stream pixel input and a fixed-latency convolver:
// frames words, strobes the convolver, buffers results and re-emits them with TLAST.
module conv_stream_sequencer #(
  parameter int IMAGE_HEIGHT = 200,
  parameter int IMAGE_WIDTH  = 200,
  parameter int NB_PIXEL     = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CONV_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_last,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  input  logic                  i_kernel_valid,
  input  logic [1:0]            i_kernel_sel,
  output logic                  o_conv_valid,
  output logic [DATA_WIDTH-1:0] o_conv_data,
  output logic [1:0]            o_conv_kernel_sel,
  input  logic [DATA_WIDTH-1:0] i_conv_data,
  output logic                  o_frame_done,
  output logic                  o_len_err
);

  localparam int WORDS_PER_FRAME = IMAGE_WIDTH * IMAGE_HEIGHT * NB_PIXEL / DATA_WIDTH;
  localparam int CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + CONV_LATENCY + 2) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_count;
  logic [1:0]              r_kern_pend;
  logic [1:0]              r_kern_act;
  logic                    r_conv_valid;
  logic                    r_conv_last;
  logic [DATA_WIDTH-1:0]   r_conv_data;
  logic [CONV_LATENCY-1:0] r_tag_vld;
  logic [CONV_LATENCY-1:0] r_tag_last;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   r_mem_last;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [OCC_W-1:0]        r_occ;
  logic                    r_frame_done;
  logic                    r_len_err;

  logic                    w_accept;
  logic                    w_last_word;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_tags_empty;
  logic [CRD_W-1:0]        w_credit_used;

  // Every word already accepted owns a FIFO slot until it is popped.
  always_comb begin
    w_credit_used = CRD_W'(r_occ) + CRD_W'(r_conv_valid);
    for (int i = 0; i < CONV_LATENCY; i++) begin
      w_credit_used = w_credit_used + CRD_W'(r_tag_vld[i]);
    end
  end

  assign s_axis_ready = (r_state != DRAIN) && (w_credit_used < CRD_W'(FIFO_DEPTH));
  assign w_accept     = s_axis_valid && s_axis_ready;
  assign w_last_word  = (r_count == LAST_IDX);
  assign w_push       = r_tag_vld[CONV_LATENCY-1];
  assign w_empty      = (r_occ == '0);
  assign w_pop        = !w_empty && m_axis_ready;
  assign w_tags_empty = !r_conv_valid && (r_tag_vld == '0);

  assign m_axis_valid      = !w_empty;
  assign m_axis_data       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign m_axis_last       = !w_empty && r_mem_last[r_rd_ptr];
  assign o_conv_valid      = r_conv_valid;
  assign o_conv_data       = r_conv_data;
  assign o_conv_kernel_sel = r_kern_act;
  assign o_frame_done      = r_frame_done;
  assign o_len_err         = r_len_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_kern_pend  <= '0;
      r_kern_act   <= '0;
      r_conv_valid <= 1'b0;
      r_conv_last  <= 1'b0;
      r_conv_data  <= '0;
      r_tag_vld    <= '0;
      r_tag_last   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      // Stage 1: convolver strobe; stages 2..: tags aligned with the convolver latency
      r_conv_valid <= w_accept;
      r_conv_last  <= w_accept && w_last_word;
      if (w_accept) r_conv_data <= s_axis_data;
      r_tag_vld[0]  <= r_conv_valid;
      r_tag_last[0] <= r_conv_last;
      for (int i = 1; i < CONV_LATENCY; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      // Kernel changes are only adopted while no frame is open.
      if (i_kernel_valid)    r_kern_pend <= i_kernel_sel;
      if (r_state == IDLE)   r_kern_act  <= r_kern_pend;

      if (w_accept) begin
        r_count <= w_last_word ? '0 : r_count + 1'b1;
        if (s_axis_last != w_last_word) r_len_err <= 1'b1;
      end

      r_frame_done <= 1'b0;
      case (r_state)
        IDLE:    if (w_accept) r_state <= w_last_word ? DRAIN : RUN;
        RUN:     if (w_accept && w_last_word) r_state <= DRAIN;
        DRAIN: begin
          if (w_pop && r_mem_last[r_rd_ptr] && w_tags_empty) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result storage carries no reset; the empty flag masks stale entries.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]      <= i_conv_data;
      r_mem_last[r_wr_ptr] <= r_tag_last[CONV_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Scoreboard bench for conv_stream_sequencer: 8-word frames, a convolver model adding 0x100.
module tb_conv_stream_sequencer;

  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int WPF = 8;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          s_axis_valid = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_last = 1'b0;
  logic          s_axis_ready;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b1;
  logic          i_kernel_valid = 1'b0;
  logic [1:0]    i_kernel_sel = 2'd0;
  logic          o_conv_valid;
  logic [DW-1:0] o_conv_data;
  logic [1:0]    o_conv_kernel_sel;
  logic [DW-1:0] i_conv_data;
  logic          o_frame_done;
  logic          o_len_err;

  conv_stream_sequencer #(
    .IMAGE_HEIGHT(8), .IMAGE_WIDTH(4), .NB_PIXEL(8), .DATA_WIDTH(DW),
    .CONV_LATENCY(LAT), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_ready(m_axis_ready),
    .i_kernel_valid(i_kernel_valid), .i_kernel_sel(i_kernel_sel),
    .o_conv_valid(o_conv_valid), .o_conv_data(o_conv_data),
    .o_conv_kernel_sel(o_conv_kernel_sel), .i_conv_data(i_conv_data),
    .o_frame_done(o_frame_done), .o_len_err(o_len_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rmode = 0;
  int fd_cnt = 0;
  int acc0 = 0;
  bit arm_lat = 1'b0;
  int cw = 0;
  logic [1:0] cur_k = 2'd0;
  logic [DW:0] sb [$];
  logic [1:0]  kq [$];
  logic [DW-1:0] cpipe [LAT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Convolver model with the configured latency.
  always @(posedge i_clk) begin
    cpipe[0] <= o_conv_data + 32'h100;
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign i_conv_data = cpipe[LAT-1];

  always @(negedge i_clk) begin
    logic [DW:0] e;
    case (rmode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = 1'b0;
      default: m_axis_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (o_frame_done) fd_cnt++;
    if (arm_lat && m_axis_valid) begin
      chk("first_out_latency", cyc - acc0, 4);
      arm_lat = 1'b0;
    end
    if (m_axis_valid && m_axis_ready) begin
      e = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("out_data", m_axis_data, e[DW-1:0]);
      chk("out_last", m_axis_last, e[DW]);
    end
    if (o_conv_valid) begin
      if (cw == 0) cur_k = (kq.size() > 0) ? kq.pop_front() : 2'bx;
      chk("conv_kernel", o_conv_kernel_sel, cur_k);
      cw = (cw == WPF - 1) ? 0 : cw + 1;
    end
  end

  task automatic send(input logic [DW-1:0] d, input int idx, input bit lst, input bit thr,
                      input bit kw, input logic [1:0] ks);
    int n = 0;
    bit acc = 1'b0;
    while (!acc && n < 2000) begin
      @(negedge i_clk);
      i_kernel_valid = 1'b0;
      s_axis_valid = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_data = d;
      s_axis_last = lst;
      acc = s_axis_valid && s_axis_ready;
      if (acc && kw) begin
        i_kernel_valid = 1'b1;
        i_kernel_sel = ks;
      end
      n++;
    end
    if (!acc) chk("accept_timeout", acc, 1);
    else sb.push_back({(idx == WPF - 1), d + 32'h100});
  endtask

  task automatic idle();
    @(negedge i_clk);
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    i_kernel_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp);
    int n = 0;
    while (fd_cnt < exp && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    chk("frame_done_count", fd_cnt, exp);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic stream_frame(input logic [DW-1:0] base);
    for (int i = 0; i < WPF; i++) begin
      send(base + DW'(i), i, (i == WPF - 1), 1'b0, 1'b0, 2'd0);
      if (i == 0) begin
        acc0 = cyc;
        arm_lat = 1'b1;
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    repeat (3) @(negedge i_clk);
    chk("rst_m_valid", m_axis_valid, 0);
    chk("rst_m_last", m_axis_last, 0);
    chk("rst_m_data", m_axis_data, 0);
    chk("rst_conv_valid", o_conv_valid, 0);
    chk("rst_conv_data", o_conv_data, 0);
    chk("rst_kernel", o_conv_kernel_sel, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_len_err", o_len_err, 0);
    chk("rst_s_ready", s_axis_ready, 1);
    i_reset = 1'b0;

    // Streaming frame
    kq.push_back(2'd0);
    stream_frame(32'h1);
    wait_done(1);
    chk("stream_lat_seen", arm_lat, 0);
    chk("stream_len_err", o_len_err, 0);

    // Backpressure: output stalled, input held valid
    kq.push_back(2'd0);
    rmode = 1;
    idx = 0;
    repeat (20) begin
      @(negedge i_clk);
      s_axis_valid = 1'b1;
      s_axis_data = 32'h11 + DW'(idx);
      s_axis_last = (idx == WPF - 1);
      if (s_axis_ready) begin
        sb.push_back({(idx == WPF - 1), s_axis_data + 32'h100});
        idx++;
      end
    end
    chk("bp_accepted", idx, 4);
    chk("bp_ready_low", s_axis_ready, 0);
    chk("bp_pending", sb.size(), 4);
    rmode = 0;
    for (int i = idx; i < WPF; i++) send(32'h11 + DW'(i), i, (i == WPF - 1), 1'b0, 1'b0, 2'd0);
    idle();
    wait_done(2);

    // Kernel timing: mid-frame write, then a write coinciding with a frame's first accept
    kq.push_back(2'd0);
    for (int i = 0; i < 4; i++) send(32'h21 + DW'(i), i, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge i_clk);
    s_axis_valid = 1'b0;
    i_kernel_valid = 1'b1;
    i_kernel_sel = 2'd2;
    for (int i = 4; i < WPF; i++) send(32'h21 + DW'(i), i, (i == WPF - 1), 1'b0, 1'b0, 2'd0);
    idle();
    wait_done(3);
    kq.push_back(2'd2);
    for (int i = 0; i < WPF; i++) send(32'h31 + DW'(i), i, (i == WPF - 1), 1'b0, (i == 0), 2'd3);
    idle();
    wait_done(4);
    kq.push_back(2'd3);
    stream_frame(32'h41);
    wait_done(5);

    // Length error: early TLAST on word 5
    kq.push_back(2'd3);
    for (int i = 0; i < WPF; i++) begin
      send(32'h51 + DW'(i), i, (i == 4) || (i == WPF - 1), 1'b0, 1'b0, 2'd0);
      if (i == 5) chk("len_err_set", o_len_err, 1);
    end
    idle();
    wait_done(6);
    chk("len_err_sticky", o_len_err, 1);

    // Reset mid-frame
    kq.push_back(2'd3);
    for (int i = 0; i < 3; i++) send(32'h61 + DW'(i), i, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge i_clk);
    s_axis_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_m_valid", m_axis_valid, 0);
    chk("mid_rst_m_last", m_axis_last, 0);
    chk("mid_rst_m_data", m_axis_data, 0);
    chk("mid_rst_conv_valid", o_conv_valid, 0);
    chk("mid_rst_conv_data", o_conv_data, 0);
    chk("mid_rst_kernel", o_conv_kernel_sel, 0);
    chk("mid_rst_frame_done", o_frame_done, 0);
    chk("mid_rst_len_err", o_len_err, 0);
    i_reset = 1'b0;
    sb.delete();
    kq.delete();
    cw = 0;
    kq.push_back(2'd0);
    stream_frame(32'h71);
    wait_done(7);
    chk("post_rst_lat_seen", arm_lat, 0);
    chk("post_rst_len_err", o_len_err, 0);

    // Random throttling on both sides over five frames
    rmode = 2;
    repeat (5) kq.push_back(2'd0);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < WPF; i++) send($urandom, i, (i == WPF - 1), 1'b1, 1'b0, 2'd0);
    end
    idle();
    wait_done(12);
    rmode = 0;
    chk("rand_len_err", o_len_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
